// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared definitions for the multicycle arithmetic blocks: FSM state encoding
// and the operand/chunk geometry check used at elaboration.
package multicycle_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/multicycle_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder made of full-adder cells; also
// exposes the carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s_o[gi]  = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]  = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o  = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// WIDTH-bit adder that processes CHUNK bits per clock, LSB chunk first, with
// a start/busy/done handshake. Results stay put until the next op's first chunk.
module multicycle_chunk_adder
  import multicycle_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("multicycle_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_co, chunk_cmsb;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .cin_i  (carry_q),
    .s_o    (chunk_s),
    .cout_o (chunk_co),
    .c_msb_o(chunk_cmsb)
  );

  always_comb begin
    s_d = s_q;
    s_d[idx_q*CHUNK +: CHUNK] = chunk_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          s_q     <= s_d;
          carry_q <= chunk_co;
          if (idx_q == LAST_IDX) begin
            // Overflow is the carry into the MSB disagreeing with the carry out.
            cout_q  <= chunk_co;
            ovf_q   <= chunk_co ^ chunk_cmsb;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Self-checking bench: 16/4 instance for directed, table and random ops, plus
// a 4/4 instance swept exhaustively with start held high.
module tb_multicycle_chunk_adder;

  localparam int W16 = 16;
  localparam int C16 = 4;
  localparam int N16 = W16 / C16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start16 = 1'b0, cin16 = 1'b0;
  logic [W16-1:0]  a16 = '0, b16 = '0;
  logic            busy16, done16, cout16, ovf16;
  logic [W16-1:0]  s16;

  logic            start4 = 1'b0, cin4 = 1'b0;
  logic [3:0]      a4 = '0, b4 = '0;
  logic            busy4, done4, cout4, ovf4;
  logic [3:0]      s4;

  multicycle_chunk_adder #(.WIDTH(W16), .CHUNK(C16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .a_i(a16), .b_i(b16), .cin_i(cin16),
    .busy_o(busy16), .done_o(done16), .s_o(s16), .cout_o(cout16), .ovf_o(ovf16)
  );

  multicycle_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
    .busy_o(busy4), .done_o(done4), .s_o(s4), .cout_o(cout4), .ovf_o(ovf4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Reference: packs {ovf, cout, s} from plain unsigned/signed integer arithmetic.
  function automatic logic [31:0] model(input int w, input longint a, input longint b,
                                        input longint c);
    longint m, half, sum, sa, sb, ssum;
    logic [31:0] r;
    m    = longint'(1) << w;
    half = m / 2;
    sum  = a + b + c;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    ssum = sa + sb + c;
    r    = 32'(sum % m);
    r[w]   = (sum >= m);
    r[w+1] = (ssum >= half) || (ssum < -half);
    return r;
  endfunction

  // One op on dut16 with start pulsed; checks busy span and done latency.
  task automatic run16(input logic [W16-1:0] a, input logic [W16-1:0] b, input logic c,
                       input string nm, output logic [31:0] res);
    int cycles;
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    @(posedge clk); #1;
    start16 = 1'b0;
    cycles = 0;
    while (!done16 && cycles < 20) begin
      if (!busy16) begin
        vectors++; miscompares++;
        $display("FAIL %s busy: got 0, expected 1 at cycle %0d", nm, cycles);
      end
      @(posedge clk); #1;
      cycles++;
    end
    chk({nm, " latency"}, 32'(cycles), 32'(N16));
    chk({nm, " busy@done"}, 32'(busy16), 32'd0);
    res = 32'(s16);
    res[W16]   = cout16;
    res[W16+1] = ovf16;
    @(posedge clk); #1;
    chk({nm, " done pulse"}, 32'(done16), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  vec_t tbl[5];
  logic [31:0] res;
  int ndone;

  initial begin
    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h8001, 16'hFFFE, 1'b1, 16'h8000, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset s", 32'(s16), 32'd0);
    chk("reset busy/done/cout/ovf", {28'd0, busy16, done16, cout16, ovf16}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run16(tbl[i].a, tbl[i].b, tbl[i].cin, $sformatf("tbl%0d", i), res);
      chk($sformatf("tbl%0d s", i), 32'(res[15:0]), 32'(tbl[i].s));
      chk($sformatf("tbl%0d cout", i), 32'(res[16]), 32'(tbl[i].cout));
      chk($sformatf("tbl%0d ovf", i), 32'(res[17]), 32'(tbl[i].ovf));
    end

    for (int i = 0; i < 25; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run16(ra, rb, rc, $sformatf("rnd%0d", i), res);
      chk($sformatf("rnd%0d %h+%h+%0d", i, ra, rb, rc), res,
          model(W16, longint'(ra), longint'(rb), longint'(rc)));
    end

    // start re-pulsed during RUN must be ignored
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    start16 = 1'b1; a16 = 16'hAAAA;
    @(negedge clk);
    start16 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done16) begin
        ndone++;
        chk("repulse s", 32'(s16), 32'h0002);
      end
    end
    chk("repulse done count", 32'(ndone), 32'd1);
    chk("repulse back to idle", 32'(busy16), 32'd0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async rst s", 32'(s16), 32'd0);
    chk("async rst busy/done/cout/ovf", {28'd0, busy16, done16, cout16, ovf16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    chk("no done after rst", 32'(ndone), 32'd0);
    run16(16'h0F0F, 16'h00F1, 1'b1, "post-rst", res);
    chk("post-rst result", res, model(W16, 64'h0F0F, 64'h00F1, 64'd1));

    // Exhaustive back-to-back sweep on the 4-bit single-chunk instance
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] nx;
      logic [31:0] got4;
      nx = 9'(i + 1);
      a4 = nx[3:0]; b4 = nx[7:4]; cin4 = nx[8];
      if (i == 511) start4 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("sw%0d done", i), 32'(done4), 32'd1);
      got4 = {26'd0, ovf4, cout4, s4};
      chk($sformatf("sw%0d %0d+%0d+%0d", i, i % 16, (i / 16) % 16, i / 256), got4,
          model(4, longint'(i % 16), longint'((i / 16) % 16), longint'(i / 256)));
      @(posedge clk); #1;
      chk($sformatf("sw%0d gap", i), 32'(done4), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_chunk_adder.md
Name: multicycle_chunk_adder

Overview:
Parametrised successor to the team's fixed 4-bit combinational adders. It adds two WIDTH-bit operands plus carry-in over several clock cycles, processing CHUNK bits per cycle, LSB chunk first, with the carry held in a register between chunks. A start/busy/done handshake lets a controller or datapath trade area for latency. Results are held stable until the next accepted operation.

Parameters:
WIDTH, 16, operand and sum width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK, WIDTH/CHUNK, derived localparam: number of add cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request an operation; sampled only when the block is accepting (IDLE or DONE).
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
cin  input  1  carry-in; sampled on the accepting edge.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse: s, cout and ovf are valid.
s  output  WIDTH  sum, registered.
cout  output  1  unsigned carry-out of bit WIDTH-1, registered.
ovf  output  1  two's-complement overflow, registered: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0; done=0; s=0; cout=0; ovf=0; chunk index=0; carry register=0; operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b and cin, set index=0, and go to RUN (busy=1 from the next cycle). Otherwise stay in IDLE.
- RUN: each edge adds chunk[index] of A and B plus the carry register. The CHUNK-bit result goes into s[index*CHUNK +: CHUNK] and the chunk carry-out goes into the carry register. index increments.
  - On the edge that processes index=NCHUNK-1: update cout, compute ovf from the MSB carries, and go to DONE.
  - start is ignored in RUN. It is not queued and the latched operands do not change.
- DONE: done=1 and busy=0 for exactly one cycle.
  - If start=1 in this cycle, the new operands are accepted and the next state is RUN (back-to-back operations).
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge k, so busy is high for edges k+1..k+NCHUNK, and done is high in the cycle following edge k+NCHUNK. Back-to-back throughput is one result per NCHUNK+1 cycles.
- s, cout and ovf are held unchanged from done until the edge that completes the first chunk of the next operation.
  - s may change chunk-by-chunk during RUN.
  - Consumers must sample only when done=1.
- Width rules: all arithmetic is unsigned and modulo 2^WIDTH. The carry register is 1 bit. No sign extension inside the block.
- CHUNK=WIDTH (NCHUNK=1): RUN lasts one cycle and done is high two cycles after start is sampled.
- Reset mid-RUN: the operation is aborted, all outputs return to reset values, and no done pulse is issued.
- start held high continuously: operations repeat back-to-back, each re-sampling a, b and cin in DONE.

Decomposition:
- Shared include/package: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a WIDTH%CHUNK==0 elaboration check. Shared with future multicycle arithmetic blocks.
- One sub-module: chunk_adder, a combinational CHUNK-bit ripple-carry adder built from the existing full adder cell.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb (carry into the top bit, used for ovf).
- The top level holds the FSM, index counter, operand shift/select, carry register and result registers.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x1234, b=0x1111, cin=0, start pulsed -> busy for 4 cycles; done on cycle 5; s=0x2345, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Confirms the carry ripples across all 4 chunk boundaries.
- a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 -> s=0x0000, cout=1, ovf=1.
- start re-pulsed with a=0xAAAA during RUN of 0x0001+0x0001 -> ignored; done once with s=0x0002, then state returns to IDLE.
- rst asserted asynchronously mid-RUN (between clock edges) -> s, cout, ovf, busy and done go to 0 immediately; no done pulse; the next start then completes normally.
- start held high; CHUNK=WIDTH=4 build; exhaustive sweep of all 512 (a, b, cin) combinations back-to-back -> each done matches a+b+cin, and done fires every 2 cycles.
